obstacle_scheduler: RTL and testbench

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

---
 rtl/obstacle_scheduler.sv | 97 +++++++++
 tb/tb_obstacle_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: loads a jittered interval into an external down-counter,
// waits for it to expire, then emits a spawn event with an LFSR-chosen obstacle type.
module obstacle_scheduler #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [8:0]  BASE_GAP  = 9'd320,
  parameter logic [8:0]  GAP_STEP  = 9'd32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_run,
  input  logic       clear_count,
  input  logic [2:0] speed_level,
  input  logic [8:0] count_in,
  output logic       load_en,
  output logic [8:0] load_data,
  output logic       spawn_pulse,
  output logic [1:0] obstacle_type,
  output logic [7:0] spawn_count
);

  // An all-zero seed would lock the LFSR, so it is substituted.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, SPAWN} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic        wait_guard;
  logic [15:0] lfsr_next;

  // Base interval is floored at 64 ticks; the wide product avoids wrap on underflow.
  function automatic logic [8:0] calc_interval(input logic [2:0] lvl, input logic [5:0] jitter);
    logic [11:0] dec;
    logic [8:0]  base;
    dec = 12'(GAP_STEP) * 12'(lvl);
    if (dec + 12'd64 > 12'(BASE_GAP))
      base = 9'd64;
    else
      base = BASE_GAP - dec[8:0];
    return base + {3'b000, jitter};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lfsr          <= SEED;
      wait_guard    <= 1'b0;
      load_en       <= 1'b0;
      load_data     <= 9'd0;
      spawn_pulse   <= 1'b0;
      obstacle_type <= 2'd0;
      spawn_count   <= 8'd0;
    end else begin
      load_en     <= 1'b0;
      spawn_pulse <= 1'b0;
      if (clear_count)
        spawn_count <= 8'd0;
      if (!game_run) begin
        state      <= IDLE;
        wait_guard <= 1'b0;
      end else begin
        if (state != IDLE)
          lfsr <= lfsr_next;
        case (state)
          IDLE, SPAWN: begin
            state     <= LOAD;
            load_en   <= 1'b1;
            load_data <= calc_interval(speed_level, lfsr[5:0]);
          end
          LOAD: begin
            state      <= WAIT;
            wait_guard <= 1'b1;
          end
          WAIT: begin
            // First WAIT cycle may still see the counter's pre-load value.
            if (wait_guard) begin
              wait_guard <= 1'b0;
            end else if (count_in == 9'd0) begin
              state         <= SPAWN;
              spawn_pulse   <= 1'b1;
              obstacle_type <= lfsr[7:6];
              if (!clear_count)
                spawn_count <= sat_inc(spawn_count);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomized bench for obstacle_scheduler with an event-level reference model and a
// modelled downstream down-counter.
module tb_obstacle_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game_run;
  logic       clear_count;
  logic [2:0] speed_level;
  logic [8:0] count_in;
  logic       load_en;
  logic [8:0] load_data;
  logic       spawn_pulse;
  logic [1:0] obstacle_type;
  logic [7:0] spawn_count;

  obstacle_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .game_run     (game_run),
    .clear_count  (clear_count),
    .speed_level  (speed_level),
    .count_in     (count_in),
    .load_en      (load_en),
    .load_data    (load_data),
    .spawn_pulse  (spawn_pulse),
    .obstacle_type(obstacle_type),
    .spawn_count  (spawn_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_busy, m_load, m_spawn;
  int          m_wait;
  int          m_ld, m_type, m_cnt, m_lvl_used;
  logic [15:0] m_lfsr;
  int          ds_cnt;
  int          cnt_mode;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    int taps[4] = '{16, 14, 13, 11};
    bit fb = 1'b0;
    foreach (taps[i]) fb ^= v[taps[i]-1];
    return {v[14:0], fb};
  endfunction

  function automatic int interval_ref(input int lvl, input logic [15:0] v);
    int b;
    b = 320 - 32 * lvl;
    if (b < 64) b = 64;
    return b + int'(v[5:0]);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_load = 0; m_spawn = 0; m_wait = -1;
    m_ld = 0; m_type = 0; m_cnt = 0; m_lvl_used = 0;
    m_lfsr = 16'hACE1; ds_cnt = 0;
  endtask

  task automatic model_update();
    logic [15:0] pre;
    bit nl, ns;
    nl = 0; ns = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_load) ds_cnt = m_ld;
    else if (ds_cnt > 0) ds_cnt--;
    pre = m_lfsr;
    if (!game_run) begin
      m_busy = 0;
      m_wait = -1;
    end else begin
      if (m_busy) m_lfsr = lfsr_adv(m_lfsr);
      if (!m_busy || m_spawn) begin
        nl = 1;
        m_ld = interval_ref(int'(speed_level), pre);
        m_lvl_used = int'(speed_level);
        m_busy = 1;
      end else if (m_load) begin
        m_wait = 0;
      end else if (m_wait >= 1 && count_in == 9'd0) begin
        ns = 1;
        m_type = int'(pre[7:6]);
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_wait++;
      end
    end
    if (clear_count) m_cnt = 0;
    m_load = nl;
    m_spawn = ns;
  endtask

  task automatic set_cin();
    case (cnt_mode)
      0: count_in = 9'(ds_cnt);
      1: count_in = 9'd0;
      2: count_in = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_val("load_en", 32'(load_en), 32'(m_load));
    check_val("spawn_pulse", 32'(spawn_pulse), 32'(m_spawn));
    check_val("load_data", 32'(load_data), 32'(m_ld));
    check_val("obstacle_type", 32'(obstacle_type), 32'(m_type));
    check_val("spawn_count", 32'(spawn_count), 32'(m_cnt));
    if (m_load && m_lvl_used == 7)
      check_val("lvl7_range", 32'(load_data >= 9'd96 && load_data <= 9'd159), 32'd1);
    set_cin();
  endtask

  initial begin
    int  saved_cnt;
    bit  seen;
    rst_n = 1'b0; game_run = 1'b0; clear_count = 1'b0; speed_level = 3'd0; count_in = 9'd0;
    cnt_mode = 0;
    model_reset();
    #12;
    check_val("rst_load_en", 32'(load_en), 32'd0);
    check_val("rst_spawn_pulse", 32'(spawn_pulse), 32'd0);
    check_val("rst_load_data", 32'(load_data), 32'd0);
    check_val("rst_type", 32'(obstacle_type), 32'd0);
    check_val("rst_count", 32'(spawn_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(); step();

    // First interval from seed at speed 0, then one modelled countdown to a spawn
    game_run = 1'b1;
    step();
    check_val("first_load_en", 32'(load_en), 32'd1);
    check_val("first_load_data", 32'(load_data), 32'd353);
    seen = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (spawn_pulse) begin seen = 1; break; end
    end
    check_val("first_spawn_seen", 32'(seen), 32'd1);
    check_val("first_spawn_count", 32'(spawn_count), 32'd1);
    step();
    check_val("reload_after_spawn", 32'(load_en), 32'd1);

    // game_run drops in the same cycle count_in reaches zero
    cnt_mode = 3;
    seen = 0;
    for (int i = 0; i < 800; i++) begin
      if (m_load) begin seen = 1; break; end
      count_in = 9'd7;
      step();
    end
    check_val("reach_load", 32'(seen), 32'd1);
    count_in = 9'd5;
    step(); step();
    saved_cnt = m_cnt;
    count_in = 9'd0; game_run = 1'b0;
    step();
    check_val("drop_no_spawn", 32'(spawn_pulse), 32'd0);
    check_val("drop_count_held", 32'(spawn_count), 32'(saved_cnt));
    step();
    check_val("drop_idle_no_load", 32'(load_en), 32'd0);

    // Saturation with count_in forced to zero, then clear colliding with a spawn
    cnt_mode = 1; game_run = 1'b1; clear_count = 1'b1; speed_level = 3'd3;
    step();
    clear_count = 1'b0;
    repeat (1100) step();
    check_val("sat_255", 32'(spawn_count), 32'd255);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_busy && !m_load && !m_spawn && m_wait >= 1) begin
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        check_val("clr_spawn_pulse", 32'(spawn_pulse), 32'd1);
        check_val("clr_with_spawn", 32'(spawn_count), 32'd0);
        seen = 1;
        break;
      end
      step();
    end
    check_val("clr_window_found", 32'(seen), 32'd1);

    // Randomized operation
    cnt_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      game_run = ($urandom_range(0, 39) != 0);
      clear_count = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) speed_level = 3'($urandom_range(0, 7));
      step();
    end
    clear_count = 1'b0;

    // Full countdowns at the fastest speed
    cnt_mode = 0; game_run = 1'b1; speed_level = 3'd7;
    set_cin();
    repeat (600) step();

    // Asynchronous reset in the middle of WAIT
    speed_level = 3'd0;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_busy && !m_load && !m_spawn && m_wait >= 1) begin seen = 1; break; end
      step();
    end
    check_val("reach_wait", 32'(seen), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_load_en", 32'(load_en), 32'd0);
    check_val("arst_spawn_pulse", 32'(spawn_pulse), 32'd0);
    check_val("arst_load_data", 32'(load_data), 32'd0);
    check_val("arst_type", 32'(obstacle_type), 32'd0);
    check_val("arst_count", 32'(spawn_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_val("reseed_load_en", 32'(load_en), 32'd1);
    check_val("reseed_load_data", 32'(load_data), 32'd353);
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
